// File: rtl/pattern_match_engine.sv
// Pattern match engine: stores one string, then matches a stream of patterns
// against it. Supports literals, '.', '^', '$' and a single '*'. Reports the
// leftmost (MODE=0) or rightmost (MODE=1) match start, with optional A-Z case
// folding and an error flag for overflow or malformed patterns.
module pattern_match_engine #(
  parameter  int STR_MAX  = 32,
  parameter  int PAT_MAX  = 8,
  parameter  int DATA_W   = 8,
  parameter  int MODE     = 0,
  parameter  int CASE_INS = 0,
  localparam int IDX_W    = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic              valid,
  output logic              err,
  output logic              busy
);

  localparam int SLW = IDX_W + 1;
  localparam int CW  = $clog2(PAT_MAX + 1);
  localparam int PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int PW  = ((SLW > CW) ? SLW : CW) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD_STR = 3'd1;
  localparam logic [2:0] S_LD_PAT = 3'd2;
  localparam logic [2:0] S_SEARCH = 3'd3;
  localparam logic [2:0] S_SUFFIX = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam logic [DATA_W-1:0] CH_DOT    = DATA_W'(8'h2E);
  localparam logic [DATA_W-1:0] CH_CARET  = DATA_W'(8'h5E);
  localparam logic [DATA_W-1:0] CH_DOLLAR = DATA_W'(8'h24);
  localparam logic [DATA_W-1:0] CH_STAR   = DATA_W'(8'h2A);
  localparam logic [DATA_W-1:0] CH_SPACE  = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] CH_UA     = DATA_W'(8'h41);
  localparam logic [DATA_W-1:0] CH_UZ     = DATA_W'(8'h5A);

  logic [2:0]        state;
  logic [SLW-1:0]    str_len;
  logic [SLW-1:0]    s;
  logic [CW-1:0]     pat_len;
  logic [PW-1:0]     t;
  logic              ovf;
  logic [DATA_W-1:0] str_mem [STR_MAX];
  logic [DATA_W-1:0] pat_mem [PAT_MAX];

  logic              str_we, pat_we;
  logic [IDX_W-1:0]  str_wa;
  logic [PIW-1:0]    pat_wa;

  logic              has_star, multi_star, err_cond;
  logic [CW-1:0]     star_pos, p_cons, q_cons;

  logic [PW-1:0]     ev_base, sl_x, pos, off, t0, t_max;
  logic [CW-1:0]     ev_lo, ev_hi;
  logic [DATA_W-1:0] c;
  logic              ev_hit, range_ok, s_last;
  logic [SLW-1:0]    s_next, s_init;

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] ch);
    if (CASE_INS != 0 && ch >= CH_UA && ch <= CH_UZ) return ch | CH_SPACE;
    return ch;
  endfunction

  assign busy = (state == S_SEARCH) || (state == S_SUFFIX) || (state == S_OUT);

  // Character store write enables; string chars take priority over pattern chars
  always_comb begin
    str_we = isstring && ((state == S_IDLE) ||
                          (state == S_LD_STR && str_len < SLW'(STR_MAX)));
    str_wa = (state == S_IDLE) ? '0 : str_len[IDX_W-1:0];
    pat_we = ispattern && !isstring &&
             ((state == S_IDLE) || (state == S_LD_STR) ||
              (state == S_LD_PAT && pat_len < CW'(PAT_MAX)));
    pat_wa = (state == S_LD_PAT) ? pat_len[PIW-1:0] : '0;
  end

  // String and pattern character storage (no reset: lengths qualify contents)
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_wa] <= chardata;
    if (pat_we) pat_mem[pat_wa] <= chardata;
  end

  // Pattern decode: star location/count and consuming-char counts of P and Q
  always_comb begin
    has_star   = 1'b0;
    multi_star = 1'b0;
    star_pos   = pat_len;
    p_cons     = '0;
    q_cons     = '0;
    for (int unsigned k = 0; k < PAT_MAX; k++) begin
      if (CW'(k) < pat_len) begin
        if (pat_mem[k] == CH_STAR) begin
          if (has_star) multi_star = 1'b1;
          else          star_pos   = CW'(k);
          has_star = 1'b1;
        end else if (pat_mem[k] != CH_CARET && pat_mem[k] != CH_DOLLAR) begin
          if (has_star) q_cons = q_cons + CW'(1);
          else          p_cons = p_cons + CW'(1);
        end
      end
    end
    err_cond = ovf | multi_star | (str_len == '0) | (pat_len == '0);
  end

  // Segment evaluator: checks P at s in SEARCH, Q at t in SUFFIX, all elements at once
  always_comb begin
    sl_x    = PW'(str_len);
    ev_base = (state == S_SUFFIX) ? t : PW'(s);
    ev_lo   = (state == S_SUFFIX) ? star_pos + CW'(1) : '0;
    ev_hi   = (state == S_SUFFIX) ? pat_len : star_pos;
    ev_hit  = 1'b1;
    off     = '0;
    pos     = '0;
    c       = '0;
    for (int unsigned k = 0; k < PAT_MAX; k++) begin
      pos = ev_base + off;
      c   = pat_mem[k];
      if (CW'(k) >= ev_lo && CW'(k) < ev_hi) begin
        if (c == CH_CARET) begin
          if (!(pos == '0 || (pos <= sl_x &&
                str_mem[pos[IDX_W-1:0] - IDX_W'(1)] == CH_SPACE)))
            ev_hit = 1'b0;
        end else if (c == CH_DOLLAR) begin
          if (!(pos == sl_x || (pos < sl_x && str_mem[pos[IDX_W-1:0]] == CH_SPACE)))
            ev_hit = 1'b0;
        end else begin
          if (!(pos < sl_x && (c == CH_DOT || fold(c) == fold(str_mem[pos[IDX_W-1:0]]))))
            ev_hit = 1'b0;
          off = off + PW'(1);
        end
      end
    end
  end

  // Candidate scan bookkeeping and suffix window bounds
  always_comb begin
    t0       = PW'(s) + PW'(p_cons);
    t_max    = sl_x - PW'(q_cons);
    range_ok = (PW'(q_cons) <= sl_x) && (t0 <= t_max);
    if (MODE == 0) begin
      s_last = (s == str_len - SLW'(1));
      s_next = s + SLW'(1);
      s_init = '0;
    end else begin
      s_last = (s == '0);
      s_next = s - SLW'(1);
      s_init = str_len - SLW'(1);
    end
  end

  // Main control FSM and registered result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      ovf         <= 1'b0;
      s           <= '0;
      t           <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (isstring) begin
            str_len <= SLW'(1);
            state   <= S_LD_STR;
          end else if (ispattern) begin
            pat_len <= CW'(1);
            state   <= S_LD_PAT;
          end
        end
        S_LD_STR: begin
          if (isstring) begin
            if (str_len < SLW'(STR_MAX)) str_len <= str_len + SLW'(1);
            else                         ovf     <= 1'b1;
          end else if (ispattern) begin
            pat_len <= CW'(1);
            state   <= S_LD_PAT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LD_PAT: begin
          if (ispattern) begin
            if (pat_len < CW'(PAT_MAX)) pat_len <= pat_len + CW'(1);
            else                        ovf     <= 1'b1;
          end else begin
            s     <= s_init;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (err_cond) begin
            valid <= 1'b1;
            err   <= 1'b1;
            state <= S_OUT;
          end else if (ev_hit && !has_star) begin
            valid       <= 1'b1;
            match       <= 1'b1;
            match_index <= s[IDX_W-1:0];
            state       <= S_OUT;
          end else if (ev_hit && range_ok) begin
            t     <= t0;
            state <= S_SUFFIX;
          end else if (s_last) begin
            valid <= 1'b1;
            state <= S_OUT;
          end else begin
            s <= s_next;
          end
        end
        S_SUFFIX: begin
          if (ev_hit) begin
            valid       <= 1'b1;
            match       <= 1'b1;
            match_index <= s[IDX_W-1:0];
            state       <= S_OUT;
          end else if (t >= t_max) begin
            if (s_last) begin
              valid <= 1'b1;
              state <= S_OUT;
            end else begin
              s     <= s_next;
              state <= S_SEARCH;
            end
          end else begin
            t <= t + PW'(1);
          end
        end
        S_OUT: begin
          valid       <= 1'b0;
          match       <= 1'b0;
          err         <= 1'b0;
          match_index <= '0;
          pat_len     <= '0;
          ovf         <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_match_engine.sv
// Scoreboard bench: two engines (leftmost/case-sensitive and rightmost/case-folding)
// share one char stream; a string-level reference model predicts each result.
module tb_pattern_match_engine;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       chardata;
  logic             isstring, ispattern;
  logic             match0, valid0, err0, busy0;
  logic             match1, valid1, err1, busy1;
  logic [IDX_W-1:0] idx0, idx1;

  typedef struct {
    bit m;
    int idx;
    bit e;
  } exp_t;

  exp_t  q0[$], q1[$];
  exp_t  x0, x1;
  int    checks = 0;
  int    errors = 0;
  string cur_str = "";
  bit    ovf_pend = 1'b0;
  string tag = "init";

  always #5 clk = ~clk;

  pattern_match_engine #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DATA_W(8),
                         .MODE(0), .CASE_INS(0)) u_dut0 (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .match(match0), .match_index(idx0), .valid(valid0),
    .err(err0), .busy(busy0));

  pattern_match_engine #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DATA_W(8),
                         .MODE(1), .CASE_INS(1)) u_dut1 (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .match(match1), .match_index(idx1), .valid(valid1),
    .err(err1), .busy(busy1));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // ---------------- reference model (string level) ----------------
  function automatic logic [7:0] fold(input logic [7:0] ch, input bit ci);
    if (ci && ch >= "A" && ch <= "Z") return ch + 8'd32;
    return ch;
  endfunction

  function automatic bit seg_ok(input string str, input string seg, input int base, input bit ci);
    int L = str.len();
    int p = base;
    for (int i = 0; i < seg.len(); i++) begin
      logic [7:0] ch = seg[i];
      if (ch == "^") begin
        if (!(p == 0 || (p <= L && str[p-1] == " "))) return 1'b0;
      end else if (ch == "$") begin
        if (!(p == L || (p < L && str[p] == " "))) return 1'b0;
      end else begin
        if (p >= L) return 1'b0;
        if (!(ch == "." || fold(ch, ci) == fold(str[p], ci))) return 1'b0;
        p++;
      end
    end
    return 1'b1;
  endfunction

  function automatic int cons(input string seg);
    int n = 0;
    for (int i = 0; i < seg.len(); i++)
      if (seg[i] != "^" && seg[i] != "$") n++;
    return n;
  endfunction

  function automatic exp_t model(input string str, input string pat, input bit mode,
                                 input bit ci, input bit ovf);
    exp_t  r;
    int    L = str.len();
    int    n = pat.len();
    int    stars = 0;
    int    sp = -1;
    string P, Q;
    r.m = 1'b0; r.idx = 0; r.e = 1'b0;
    for (int i = 0; i < n; i++)
      if (pat[i] == "*") begin
        if (sp < 0) sp = i;
        stars++;
      end
    if (ovf || stars > 1 || L == 0 || n == 0) begin
      r.e = 1'b1;
      return r;
    end
    if (stars == 0) begin
      P = pat; Q = "";
    end else begin
      P = pat.substr(0, sp - 1);
      Q = pat.substr(sp + 1, n - 1);
    end
    for (int step = 0; step < L; step++) begin
      int s = mode ? (L - 1 - step) : step;
      if (seg_ok(str, P, s, ci)) begin
        if (stars == 0) begin
          r.m = 1'b1; r.idx = s; return r;
        end
        for (int t = s + cons(P); t <= L - cons(Q); t++)
          if (seg_ok(str, Q, t, ci)) begin
            r.m = 1'b1; r.idx = s; return r;
          end
      end
    end
    return r;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (q0.size() == 0) chk("dut0_unexpected_valid", int'(valid0), 0);
      else begin
        x0 = q0.pop_front();
        chk({tag, "_dut0_match"}, int'(match0), int'(x0.m));
        chk({tag, "_dut0_index"}, int'(idx0), x0.idx);
        chk({tag, "_dut0_err"},   int'(err0),   int'(x0.e));
      end
    end
  end

  always @(negedge clk) begin
    if (valid1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_valid", int'(valid1), 0);
      else begin
        x1 = q1.pop_front();
        chk({tag, "_dut1_match"}, int'(match1), int'(x1.m));
        chk({tag, "_dut1_index"}, int'(idx1), x1.idx);
        chk({tag, "_dut1_err"},   int'(err1),   int'(x1.e));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      chardata = s[i];
      isstring = 1'b1;
    end
    @(posedge clk); #1;
    isstring = 1'b0;
    if (s.len() > STR_MAX) begin
      cur_str  = s.substr(0, STR_MAX - 1);
      ovf_pend = 1'b1;
    end else begin
      cur_str = s;
    end
  endtask

  task automatic send_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(posedge clk); #1;
      chardata  = p[i];
      ispattern = 1'b1;
    end
    @(posedge clk); #1;
    ispattern = 1'b0;
  endtask

  task automatic run(input string pat, input string name);
    string stored = (pat.len() > PAT_MAX) ? pat.substr(0, PAT_MAX - 1) : pat;
    bit    ov     = ovf_pend || (pat.len() > PAT_MAX);
    int    n      = 0;
    tag = name;
    q0.push_back(model(cur_str, stored, 1'b0, 1'b0, ov));
    q1.push_back(model(cur_str, stored, 1'b1, 1'b1, ov));
    send_pat(pat);
    while ((q0.size() != 0 || q1.size() != 0) && n < 1200) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk({name, "_timeout_pending"}, q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end else begin
      @(posedge clk); #1;
      chk({name, "_busy_after"}, int'(busy0) + int'(busy1), 0);
    end
    ovf_pend = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    string s, p;
    string salph = "abAB ";
    string palph = "abA.^$*";

    reset = 1'b0; chardata = '0; isstring = 1'b0; ispattern = 1'b0;
    #2;
    chk("reset_valid", int'(valid0) + int'(valid1), 0);
    chk("reset_match", int'(match0) + int'(match1), 0);
    chk("reset_err",   int'(err0) + int'(err1), 0);
    chk("reset_busy",  int'(busy0) + int'(busy1), 0);
    chk("reset_index", int'(idx0) + int'(idx1), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    send_str("hello world");
    run("wor",  "wor");
    run("^wo",  "caret_wo");
    run("o$",   "o_dollar");
    run("l*d",  "l_star_d");
    run("z*d",  "z_star_d");
    run("l.",   "l_dot");
    run("WOR",  "upper_wor");
    run("*",    "star_only");
    run("abcdefghi", "pat_ovf");

    s = "";
    for (int i = 0; i < STR_MAX + 1; i++) s = {s, "x"};
    send_str(s);
    run("x", "str_ovf");
    send_str("hello world");
    run("a*b*", "two_stars");

    // abort a long suffix scan with an asynchronous reset
    s = "";
    for (int i = 0; i < STR_MAX; i++) s = {s, "a"};
    send_str(s);
    send_pat("a*b");
    repeat (6) @(posedge clk);
    #2;
    chk("pre_abort_busy", int'(busy0) + int'(busy1), 2);
    #1 reset = 1'b0;
    #1;
    chk("abort_valid", int'(valid0) + int'(valid1), 0);
    chk("abort_busy",  int'(busy0) + int'(busy1), 0);
    chk("abort_match", int'(match0) + int'(match1) + int'(err0) + int'(err1), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    cur_str  = "";
    ovf_pend = 1'b0;
    run("b", "after_abort_no_str");
    send_str("ab");
    run("b", "ab_b");

    for (int n = 0; n < 30; n++) begin
      if (n % 5 == 0) begin
        s = "";
        for (int i = 0, len = $urandom_range(1, STR_MAX + 2); i < len; i++)
          s = $sformatf("%s%c", s, salph[$urandom_range(0, salph.len() - 1)]);
        send_str(s);
      end
      p = "";
      for (int i = 0, len = $urandom_range(1, PAT_MAX + 1); i < len; i++)
        p = $sformatf("%s%c", p, palph[$urandom_range(0, palph.len() - 1)]);
      run(p, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
